// File: rtl/calculate_position_if.sv
// Control, tick and status signals between the teeter controller
// and the ball position integrator.
interface calculate_position_if;
    logic        i_start;
    logic        i_abort;
    logic        i_calc_time;
    logic [31:0] i_velocity;
    logic [15:0] o_position;
    logic        o_rst_v;
    logic        o_hit_left;
    logic        o_hit_right;
    logic        o_in_target;
    logic        o_win;
    logic        o_running;

    modport master (
        output i_start, i_abort, i_calc_time, i_velocity,
        input  o_position, o_rst_v, o_hit_left, o_hit_right,
        input  o_in_target, o_win, o_running
    );

    modport slave (
        input  i_start, i_abort, i_calc_time, i_velocity,
        output o_position, o_rst_v, o_hit_left, o_hit_right,
        output o_in_target, o_win, o_running
    );
endinterface

// File: rtl/calculate_position.sv
// Ball position integrator: wall clamping, velocity clear requests
// and target-window dwell detection for the teeter game.
module calculate_position #(
    parameter int          POS_SHIFT   = 8,
    parameter logic [15:0] POS_MIN     = 16'd0,
    parameter logic [15:0] POS_MAX     = 16'd255,
    parameter logic [15:0] POS_START   = 16'd128,
    parameter logic [15:0] TARGET_LO   = 16'd200,
    parameter logic [15:0] TARGET_HI   = 16'd215,
    parameter int          DWELL_TICKS = 16
) (
    input logic                  CLK,
    input logic                  i_rst,
    calculate_position_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic signed [32:0] MIN_ACC =
        33'(POS_MIN) << POS_SHIFT;
    localparam logic signed [32:0] MAX_ACC =
        (33'(POS_MAX) << POS_SHIFT) | ((33'd1 << POS_SHIFT) - 33'd1);
    localparam logic [31:0] START_ACC = 32'(POS_START) << POS_SHIFT;
    localparam logic [15:0] DWELL_END = 16'(DWELL_TICKS);

    state_t      r_state;
    logic [31:0] r_acc;
    logic [15:0] r_dwell;
    logic [15:0] r_position;
    logic        r_rst_v;
    logic        r_hit_left;
    logic        r_hit_right;
    logic        r_win;
    logic        r_running;

    logic signed [32:0] w_sum;
    logic [31:0]        w_next_acc;
    logic [15:0]        w_next_pos;
    logic               w_lo;
    logic               w_hi;
    logic               w_next_in;
    logic [15:0]        w_dwell_inc;

    // 33-bit sum so extreme velocities clamp instead of wrapping
    assign w_sum = $signed({r_acc[31], r_acc})
                 + $signed({bus.i_velocity[31], bus.i_velocity});
    assign w_lo  = (w_sum < MIN_ACC);
    assign w_hi  = (w_sum > MAX_ACC);

    always_comb begin
        w_next_acc = w_sum[31:0];
        if (w_lo)
            w_next_acc = MIN_ACC[31:0];
        else if (w_hi)
            w_next_acc = MAX_ACC[31:0];
    end

    assign w_next_pos  = w_next_acc[POS_SHIFT+15:POS_SHIFT];
    assign w_next_in   = (w_next_pos >= TARGET_LO)
                      && (w_next_pos <= TARGET_HI);
    assign w_dwell_inc = r_dwell + 16'd1;

    always_ff @(posedge CLK or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_acc       <= START_ACC;
            r_dwell     <= '0;
            r_position  <= POS_START;
            r_rst_v     <= 1'b1;
            r_hit_left  <= 1'b0;
            r_hit_right <= 1'b0;
            r_win       <= 1'b0;
            r_running   <= 1'b0;
        end else begin
            r_hit_left  <= 1'b0;
            r_hit_right <= 1'b0;
            if (bus.i_abort) begin
                r_state    <= S_IDLE;
                r_acc      <= START_ACC;
                r_dwell    <= '0;
                r_position <= POS_START;
                r_rst_v    <= 1'b1;
                r_win      <= 1'b0;
                r_running  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (bus.i_start) begin
                            r_state    <= S_RUN;
                            r_acc      <= START_ACC;
                            r_dwell    <= '0;
                            r_position <= POS_START;
                            r_rst_v    <= 1'b0;
                            r_win      <= 1'b0;
                            r_running  <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        r_rst_v <= 1'b0;
                        if (bus.i_calc_time) begin
                            r_acc       <= w_next_acc;
                            r_position  <= w_next_pos;
                            r_hit_left  <= w_lo;
                            r_hit_right <= w_hi;
                            r_rst_v     <= w_lo | w_hi;
                            r_dwell     <= w_next_in ? w_dwell_inc : 16'd0;
                            if (w_next_in && (w_dwell_inc >= DWELL_END)) begin
                                r_state   <= S_DONE;
                                r_win     <= 1'b1;
                                r_running <= 1'b0;
                                r_rst_v   <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.o_position  = r_position;
    assign bus.o_rst_v     = r_rst_v;
    assign bus.o_hit_left  = r_hit_left;
    assign bus.o_hit_right = r_hit_right;
    assign bus.o_win       = r_win;
    assign bus.o_running   = r_running;
    assign bus.o_in_target = (r_position >= TARGET_LO)
                          && (r_position <= TARGET_HI);
endmodule

// File: tb/tb_calculate_position.sv
// Directed bench for calculate_position: stepping, wall clamps,
// dwell win, abort/reset and start precedence.
module tb_calculate_position;
    logic CLK;
    logic i_rst;
    int   checks;
    int   failures;

    calculate_position_if bus ();

    calculate_position dut (
        .CLK   (CLK),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input logic [31:0] v);
        @(negedge CLK);
        bus.i_velocity  = v;
        bus.i_calc_time = 1'b1;
        @(posedge CLK);
        #1;
        bus.i_calc_time = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        bus.i_start = 1'b1;
        @(posedge CLK);
        #1;
        bus.i_start = 1'b0;
    endtask

    task automatic pulse_abort();
        @(negedge CLK);
        bus.i_abort = 1'b1;
        @(posedge CLK);
        #1;
        bus.i_abort = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        bus.i_start = 0; bus.i_abort = 0;
        bus.i_calc_time = 0; bus.i_velocity = 0;
        repeat (2) @(posedge CLK);
        #1;
        i_rst = 1'b0;
        chk("reset_pos", 32'(bus.o_position), 32'd128);
        chk("reset_rst_v", 32'(bus.o_rst_v), 32'd1);
        chk("reset_hits", 32'({bus.o_hit_left, bus.o_hit_right}), 32'd0);
        chk("reset_in_target", 32'(bus.o_in_target), 32'd0);
        chk("reset_win", 32'(bus.o_win), 32'd0);
        chk("reset_running", 32'(bus.o_running), 32'd0);
        tick(32'd256);
        chk("idle_tick_ignored", 32'(bus.o_position), 32'd128);
    endtask

    task automatic test_step();
        int bad;
        bad = 0;
        pulse_start();
        chk("start_running", 32'(bus.o_running), 32'd1);
        chk("start_rst_v", 32'(bus.o_rst_v), 32'd0);
        for (int i = 1; i <= 10; i++) begin
            tick(32'd256);
            if (bus.o_position !== 16'(128 + i) || bus.o_rst_v !== 1'b0)
                bad++;
        end
        chk("step_errors", 32'(bad), 32'd0);
        chk("step_final", 32'(bus.o_position), 32'd138);
        @(negedge CLK);
        @(posedge CLK);
        #1;
        chk("no_tick_hold", 32'(bus.o_position), 32'd138);
    endtask

    task automatic test_left_wall();
        int bad;
        bad = 0;
        pulse_abort();
        pulse_start();
        for (int i = 1; i <= 16; i++) begin
            tick(-32'sd2048);
            if (bus.o_position !== 16'(128 - 8 * i) || bus.o_hit_left !== 1'b0)
                bad++;
        end
        chk("left_approach_errors", 32'(bad), 32'd0);
        chk("land_on_min_no_hit", 32'(bus.o_rst_v), 32'd0);
        tick(-32'sd2048);
        chk("left_clamp_pos", 32'(bus.o_position), 32'd0);
        chk("left_hit_pulse", 32'(bus.o_hit_left), 32'd1);
        chk("left_rst_v_pulse", 32'(bus.o_rst_v), 32'd1);
        @(posedge CLK);
        #1;
        chk("left_hit_clears", 32'({bus.o_hit_left, bus.o_rst_v}), 32'd0);
        chk("left_pos_stays", 32'(bus.o_position), 32'd0);
    endtask

    task automatic test_right_wall();
        tick(32'h7FFF_FFFF);
        chk("right_clamp_pos", 32'(bus.o_position), 32'd255);
        chk("right_hit_pulse", 32'(bus.o_hit_right), 32'd1);
        chk("right_rst_v", 32'(bus.o_rst_v), 32'd1);
        chk("right_no_left", 32'(bus.o_hit_left), 32'd0);
        tick(32'h8000_0000);
        chk("min_vel_clamp", 32'(bus.o_position), 32'd0);
        chk("min_vel_hit_left", 32'(bus.o_hit_left), 32'd1);
        chk("min_vel_no_right", 32'(bus.o_hit_right), 32'd0);
    endtask

    task automatic test_win();
        pulse_abort();
        pulse_start();
        tick(32'd19712);
        chk("reach_205", 32'(bus.o_position), 32'd205);
        chk("in_target", 32'(bus.o_in_target), 32'd1);
        for (int i = 2; i <= 15; i++) tick(32'd0);
        chk("no_win_at_15", 32'(bus.o_win), 32'd0);
        tick(32'd0);
        chk("win_at_16", 32'(bus.o_win), 32'd1);
        chk("done_not_running", 32'(bus.o_running), 32'd0);
        chk("done_rst_v", 32'(bus.o_rst_v), 32'd1);
        tick(32'd2560);
        chk("done_frozen", 32'(bus.o_position), 32'd205);
        pulse_start();
        chk("restart_pos", 32'(bus.o_position), 32'd128);
        chk("restart_win_low", 32'(bus.o_win), 32'd0);
        chk("restart_running", 32'(bus.o_running), 32'd1);
        tick(32'd19712);
        for (int i = 2; i <= 15; i++) tick(32'd0);
        tick(32'd5120);
        chk("exit_window", 32'(bus.o_position), 32'd225);
        chk("exit_no_win", 32'(bus.o_win), 32'd0);
        tick(-32'sd5120);
        for (int i = 2; i <= 15; i++) tick(32'd0);
        chk("dwell_cleared_no_win", 32'(bus.o_win), 32'd0);
        tick(32'd0);
        chk("win_after_return", 32'(bus.o_win), 32'd1);
    endtask

    task automatic test_abort_reset();
        pulse_start();
        tick(32'd13312);
        chk("reach_180", 32'(bus.o_position), 32'd180);
        pulse_abort();
        chk("abort_pos", 32'(bus.o_position), 32'd128);
        chk("abort_rst_v", 32'(bus.o_rst_v), 32'd1);
        chk("abort_idle", 32'({bus.o_running, bus.o_win}), 32'd0);
        chk("abort_no_hits", 32'({bus.o_hit_left, bus.o_hit_right}), 32'd0);
        pulse_start();
        tick(32'd13312);
        @(negedge CLK);
        #2;
        i_rst = 1'b1;
        #1;
        chk("async_rst_pos", 32'(bus.o_position), 32'd128);
        chk("async_rst_rst_v", 32'(bus.o_rst_v), 32'd1);
        chk("async_rst_idle", 32'({bus.o_running, bus.o_win,
            bus.o_hit_left, bus.o_hit_right}), 32'd0);
        @(negedge CLK);
        i_rst = 1'b0;
    endtask

    task automatic test_start_precedence();
        @(negedge CLK);
        bus.i_start     = 1'b1;
        bus.i_calc_time = 1'b1;
        bus.i_velocity  = 32'd2560;
        @(posedge CLK);
        #1;
        bus.i_start     = 1'b0;
        bus.i_calc_time = 1'b0;
        chk("start_wins_pos", 32'(bus.o_position), 32'd128);
        chk("start_wins_running", 32'(bus.o_running), 32'd1);
        tick(32'd2560);
        chk("first_run_tick", 32'(bus.o_position), 32'd138);
        pulse_start();
        chk("start_in_run_ignored", 32'(bus.o_position), 32'd138);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_step();
        test_left_wall();
        test_right_wall();
        test_win();
        test_abort_reset();
        test_start_precedence();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
